// File: rtl/xgmii_tx_framer.sv
// XGMII transmit framer: pops FIFO words, forwards START..TERM packets, enforces
// the inter-frame gap and aborts on underrun or over-length with an ERROR word.
module xgmii_tx_framer #(
  parameter int IFG_WORDS = 1,
  parameter int MAX_WORDS = 192,
  parameter int CNT_W     = 16
) (
  input  logic             xgmii_tx_clk,
  input  logic             sys_rst,
  input  logic [71:0]      dout,
  input  logic             empty,
  output logic             rd_en,
  output logic             rd_clk,
  output logic [71:0]      xgmii_txd,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  // state | meaning
  // HUNT  | output IDLE, pop and discard until a START word is seen
  // DATA  | forward packet words until TERM, abort on underrun or length
  // DROP  | discard the rest of an aborted packet up to its TERM
  // GAP   | no pops, IFG_WORDS idle words after a terminate

  localparam logic [71:0] IDLE_W = {8'hff, {8{8'h07}}};
  localparam logic [71:0] ERR_W  = {8'hff, {8{8'hfe}}};
  localparam int          WC_W   = $clog2(MAX_WORDS);
  localparam logic [WC_W-1:0] LAST_CNT = WC_W'(MAX_WORDS - 1);
  localparam logic [3:0]  GAP_LOAD = (IFG_WORDS > 0) ? 4'(IFG_WORDS - 1) : 4'd0;

  typedef enum logic [1:0] {HUNT, DATA, DROP, GAP} state_t;

  state_t          state;
  logic [WC_W-1:0] word_cnt;
  logic [3:0]      gap_cnt;
  logic            term_word;
  logic            start_word;

  function automatic logic is_term(input logic [71:0] w);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (w[64+i] && (w[8*i +: 8] == 8'hfd)) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign term_word  = is_term(dout);
  assign start_word = dout[64] && (dout[7:0] == 8'hfb);

  assign rd_clk = xgmii_tx_clk;
  assign rd_en  = !sys_rst && !empty && (state != GAP);

  always_ff @(posedge xgmii_tx_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= HUNT;
      xgmii_txd <= IDLE_W;
      word_cnt  <= '0;
      gap_cnt   <= '0;
      pkt_cnt   <= '0;
      err_cnt   <= '0;
      drop_cnt  <= '0;
    end else begin
      xgmii_txd <= IDLE_W;
      case (state)
        HUNT: begin
          if (!empty) begin
            if (start_word) begin
              xgmii_txd <= dout;
              word_cnt  <= WC_W'(1);
              state     <= DATA;
            end else begin
              drop_cnt <= sat_inc(drop_cnt);
            end
          end
        end
        DATA: begin
          if (empty) begin
            xgmii_txd <= ERR_W;
            err_cnt   <= sat_inc(err_cnt);
            state     <= DROP;
          end else if (term_word) begin
            // terminate wins over the length limit on the same word
            xgmii_txd <= dout;
            pkt_cnt   <= sat_inc(pkt_cnt);
            word_cnt  <= word_cnt + WC_W'(1);
            if (IFG_WORDS == 0) begin
              state <= HUNT;
            end else begin
              state   <= GAP;
              gap_cnt <= GAP_LOAD;
            end
          end else if (word_cnt == LAST_CNT) begin
            xgmii_txd <= ERR_W;
            err_cnt   <= sat_inc(err_cnt);
            state     <= DROP;
          end else begin
            xgmii_txd <= dout;
            word_cnt  <= word_cnt + WC_W'(1);
          end
        end
        DROP: begin
          if (!empty && term_word) begin
            if (IFG_WORDS == 0) begin
              state <= HUNT;
            end else begin
              state   <= GAP;
              gap_cnt <= GAP_LOAD;
            end
          end
        end
        GAP: begin
          if (gap_cnt == 4'd0) state <= HUNT;
          else                 gap_cnt <= gap_cnt - 4'd1;
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_xgmii_tx_framer.sv
// Randomized scoreboard bench for xgmii_tx_framer, three parameter sets side by side
// (normal gap, zero gap with tiny counters and short packets, wide gap).
module tb_xgmii_tx_framer;

  localparam int NCFG  = 3;
  localparam int N_CYC = 2700;
  localparam logic [71:0] IDLE_W = {8'hff, {8{8'h07}}};
  localparam logic [71:0] ERR_W  = {8'hff, {8{8'hfe}}};

  function automatic int cfg_ifg(input int c);
    return (c == 0) ? 1 : ((c == 1) ? 0 : 3);
  endfunction
  function automatic int cfg_max(input int c);
    return (c == 0) ? 6 : ((c == 1) ? 4 : 8);
  endfunction
  function automatic int cfg_cw(input int c);
    return (c == 0) ? 16 : ((c == 1) ? 3 : 4);
  endfunction

  typedef struct {
    bit          rd;
    logic [71:0] txd;
    int          pkt;
    int          err;
    int          drop;
    bit          rst_now;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst;
  logic [NCFG-1:0]        empty_v;
  logic [NCFG-1:0]        rd_en_v;
  logic [NCFG-1:0]        rd_clk_v;
  logic [NCFG-1:0][71:0]  dout_v;
  logic [NCFG-1:0][71:0]  txd_v;
  logic [NCFG-1:0][15:0]  pkt_v;
  logic [NCFG-1:0][15:0]  err_v;
  logic [NCFG-1:0][15:0]  drop_v;

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    localparam int CW = cfg_cw(g);
    logic [CW-1:0] p, e, d;
    xgmii_tx_framer #(
      .IFG_WORDS(cfg_ifg(g)),
      .MAX_WORDS(cfg_max(g)),
      .CNT_W(CW)
    ) dut (
      .xgmii_tx_clk(clk),
      .sys_rst(rst),
      .dout(dout_v[g]),
      .empty(empty_v[g]),
      .rd_en(rd_en_v[g]),
      .rd_clk(rd_clk_v[g]),
      .xgmii_txd(txd_v[g]),
      .pkt_cnt(p),
      .err_cnt(e),
      .drop_cnt(d)
    );
    assign pkt_v[g]  = 16'(p);
    assign err_v[g]  = 16'(e);
    assign drop_v[g] = 16'(d);
  end

  logic [71:0] fifo_q[NCFG][$];
  exp_t        sb[NCFG][$];
  int          rate_tab[3] = '{3, 15, 0};

  // reference model: packet-level bookkeeping per configuration
  bit in_pkt[NCFG];
  bit discarding[NCFG];
  int len[NCFG];
  int gap_left[NCFG];
  int m_pkt[NCFG];
  int m_err[NCFG];
  int m_drop[NCFG];

  int errors = 0;
  int checks = 0;
  bit mon_done = 1'b0;

  function automatic bit w_term(input logic [71:0] w);
    for (int i = 0; i < 8; i++)
      if (w[64+i] && w[8*i +: 8] == 8'hfd) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit w_start(input logic [71:0] w);
    return w[64] && (w[7:0] == 8'hfb);
  endfunction

  function automatic int sat(input int v, input int c);
    int lim;
    lim = (1 << cfg_cw(c)) - 1;
    return (v >= lim) ? lim : v + 1;
  endfunction

  task automatic gen_packet(input int c);
    logic [71:0] w;
    int nj, nd, k;
    nj = $urandom_range(0, 2);
    repeat (nj) begin
      if ($urandom_range(0, 1) == 1) w = IDLE_W;
      else w = {8'h00, $urandom, $urandom};
      fifo_q[c].push_back(w);
    end
    w = {8'h01, 24'($urandom), $urandom, 8'hfb};
    fifo_q[c].push_back(w);
    nd = $urandom_range(0, cfg_max(c) + 1);
    repeat (nd) begin
      if ($urandom_range(0, 9) == 0) w = {8'h01, 24'($urandom), $urandom, 8'hfb};
      else w = {8'h00, $urandom, $urandom};
      fifo_q[c].push_back(w);
    end
    k = $urandom_range(0, 7);
    w = {8'h00, $urandom, $urandom};
    for (int i = 0; i < 8; i++) begin
      if (i == k) begin
        w[8*i +: 8] = 8'hfd;
        w[64+i] = 1'b1;
      end else if (i > k) begin
        w[8*i +: 8] = 8'h07;
        w[64+i] = 1'b1;
      end
    end
    fifo_q[c].push_back(w);
  endtask

  task automatic model_step(input int c, input bit r, input bit emp,
                            input logic [71:0] w, output exp_t e);
    e.rst_now = 1'b0;
    e.txd = IDLE_W;
    e.rd = 1'b0;
    if (r) begin
      in_pkt[c] = 0; discarding[c] = 0; len[c] = 0; gap_left[c] = 0;
      m_pkt[c] = 0; m_err[c] = 0; m_drop[c] = 0;
    end else begin
      e.rd = !emp && (gap_left[c] == 0);
      if (in_pkt[c]) begin
        if (emp) begin
          e.txd = ERR_W; m_err[c] = sat(m_err[c], c);
          in_pkt[c] = 0; discarding[c] = 1;
        end else if (w_term(w)) begin
          e.txd = w; m_pkt[c] = sat(m_pkt[c], c);
          in_pkt[c] = 0; gap_left[c] = cfg_ifg(c);
        end else if (len[c] + 1 >= cfg_max(c)) begin
          e.txd = ERR_W; m_err[c] = sat(m_err[c], c);
          in_pkt[c] = 0; discarding[c] = 1;
        end else begin
          e.txd = w; len[c]++;
        end
      end else if (discarding[c]) begin
        if (!emp && w_term(w)) begin
          discarding[c] = 0; gap_left[c] = cfg_ifg(c);
        end
      end else if (gap_left[c] > 0) begin
        gap_left[c]--;
      end else if (!emp) begin
        if (w_start(w)) begin
          e.txd = w; in_pkt[c] = 1; len[c] = 1;
        end else begin
          m_drop[c] = sat(m_drop[c], c);
        end
      end
    end
    e.pkt = m_pkt[c];
    e.err = m_err[c];
    e.drop = m_drop[c];
  endtask

  // stimulus: drive FIFO side on the falling edge, push expectations
  initial begin
    int rst_a, rst_b, rate;
    bit r, emp, rst_prev;
    logic [71:0] w;
    exp_t e;
    rst = 1'b1;
    empty_v = '1;
    dout_v = '0;
    rst_prev = 1'b0;
    rst_a = $urandom_range(800, 1000);
    rst_b = $urandom_range(1700, 1900);
    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(negedge clk);
      r = (cyc < 2) || (cyc >= rst_a && cyc < rst_a + 2) || (cyc >= rst_b && cyc < rst_b + 2);
      rst = r;
      rate = (cyc < 200) ? 0 : rate_tab[(cyc / 300) % 3];
      for (int c = 0; c < NCFG; c++) begin
        if (fifo_q[c].size() < 16) gen_packet(c);
        emp = ($urandom_range(0, 99) < rate);
        w = emp ? {8'($urandom), $urandom, $urandom} : fifo_q[c][0];
        empty_v[c] = emp;
        dout_v[c] = w;
        model_step(c, r, emp, w, e);
        e.rst_now = r && !rst_prev;
        sb[c].push_back(e);
        if (e.rd) void'(fifo_q[c].pop_front());
      end
      rst_prev = r;
    end
    wait (mon_done);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  task automatic chk(input string nm, input int c, input int cyc,
                     input logic [71:0] act, input logic [71:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cfg%0d cyc%0d actual=%h required=%h", nm, c, cyc, act, req);
    end
  endtask

  logic [71:0] imm_txd[NCFG];
  logic [15:0] imm_pkt[NCFG];
  logic [15:0] imm_err[NCFG];
  logic [15:0] imm_drop[NCFG];
  logic        imm_rd[NCFG];
  logic        imm_rdclk[NCFG];

  // monitor: sample rd_en before the edge, outputs after it, compare against queue
  initial begin
    exp_t e;
    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(negedge clk);
      #2;
      for (int c = 0; c < NCFG; c++) begin
        imm_txd[c]   = txd_v[c];
        imm_pkt[c]   = pkt_v[c];
        imm_err[c]   = err_v[c];
        imm_drop[c]  = drop_v[c];
        imm_rd[c]    = rd_en_v[c];
        imm_rdclk[c] = rd_clk_v[c];
      end
      @(posedge clk);
      #1;
      for (int c = 0; c < NCFG; c++) begin
        chk("rd_clk", c, cyc, 72'(imm_rdclk[c]), 72'(0));
        if (sb[c].size() == 0) begin
          chk("sb_underflow", c, cyc, 72'(0), 72'(1));
        end else begin
          e = sb[c].pop_front();
          chk("rd_en", c, cyc, 72'(imm_rd[c]), 72'(e.rd));
          chk("txd", c, cyc, txd_v[c], e.txd);
          chk("pkt_cnt", c, cyc, 72'(pkt_v[c]), 72'(e.pkt));
          chk("err_cnt", c, cyc, 72'(err_v[c]), 72'(e.err));
          chk("drop_cnt", c, cyc, 72'(drop_v[c]), 72'(e.drop));
          if (e.rst_now) begin
            chk("rst_txd", c, cyc, imm_txd[c], IDLE_W);
            chk("rst_pkt", c, cyc, 72'(imm_pkt[c]), 72'(0));
            chk("rst_err", c, cyc, 72'(imm_err[c]), 72'(0));
            chk("rst_drop", c, cyc, 72'(imm_drop[c]), 72'(0));
          end
        end
      end
    end
    for (int c = 0; c < NCFG; c++)
      chk("sb_leftover", c, N_CYC, 72'(sb[c].size()), 72'(0));
    mon_done = 1'b1;
  end

endmodule
